// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction prefetch unit: PC step, NOP encoding,
// and the queue-depth legality rule.
package ifu_prefetch_pkg;

    localparam int unsigned PC_INC   = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic bit depth_legal(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous power-of-two FIFO with flush; head is read combinationally so
// it holds steady until popped.
module ifu_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= r_wp + 1'b1;
            end
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_count = r_cnt;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues sequential ROM reads, queues {pc, inst} for
// decode, zero-bubble redirect. Optional counter under IFU_PERF_CNT_EN.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] rom_addr_o,
    output logic            rom_en_o,
    input  logic [31:0]     inst_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            de_valid_o,
    input  logic            de_ready_i,
    output logic [XLEN-1:0] de_pc_o,
    output logic [31:0]     de_inst_o
`ifdef IFU_PERF_CNT_EN
   ,output logic [31:0]     perf_fetch_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("ifu_prefetch: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;

    logic [CW-1:0]   w_occ;
    logic [CW:0]     w_need;
    logic            w_pop;
    logic            w_push;
    logic [XLEN+31:0] w_head;

    assign de_valid_o = rst_n & (w_occ != '0) & ~jump_en_i;
    assign w_pop      = de_valid_o & de_ready_i;
    assign w_push     = r_inflight & ~jump_en_i;

    // Slots already committed once this cycle's pop leaves; the new fetch needs one more.
    assign w_need   = {1'b0, w_occ} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign rom_en_o = rst_n & (jump_en_i | (w_need < (CW+1)'(DEPTH)));
    assign rom_addr_o = !rst_n    ? RESET_PC    :
                        jump_en_i ? jump_addr_i : r_fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            r_inflight <= rom_en_o;
            if (rom_en_o) begin
                r_inflight_pc <= rom_addr_o;
                r_fetch_pc    <= rom_addr_o + XLEN'(PC_INC);
            end
        end
    end

    ifu_fifo #(
        .W     (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (jump_en_i),
        .i_wdata ({r_inflight_pc, inst_i}),
        .o_rdata (w_head),
        .o_count (w_occ)
    );

    assign de_pc_o   = w_head[XLEN+31:32];
    assign de_inst_o = w_head[31:0];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)     r_perf_cnt <= '0;
        else if (w_pop) r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_fetch_cnt_o = r_perf_cnt;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: stream, stall, redirects, PC wrap, reset.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        de_ready_i = 1'b0;
    logic [31:0] inst_i;
    logic [31:0] rom_addr_o;
    logic        rom_en_o;
    logic        de_valid_o;
    logic [31:0] de_pc_o;
    logic [31:0] de_inst_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int nen;

    ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr_o  (rom_addr_o),
        .rom_en_o    (rom_en_o),
        .inst_i      (inst_i),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .de_valid_o  (de_valid_o),
        .de_ready_i  (de_ready_i),
        .de_pc_o     (de_pc_o),
        .de_inst_o   (de_inst_o)
`ifdef IFU_PERF_CNT_EN
       ,.perf_fetch_cnt_o (perf_fetch_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // ROM: one-cycle read latency, data tagged by address.
    always @(posedge clk) inst_i <= rom_en_o ? (rom_addr_o ^ K) : INST_NOP;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0; jump_en_i = 1'b0; de_ready_i = rdy;
        nxt(); nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0; de_ready_i = 1'b1;
        nxt(); nxt();
        smp();
        chk("rst_en",    rom_en_o,   0);
        chk("rst_addr",  rom_addr_o, 0);
        chk("rst_valid", de_valid_o, 0);
        chk("rst_pc",    de_pc_o,    0);
        chk("rst_inst",  de_inst_o,  0);
        nxt();
        rst_n = 1'b1;

        // Sequential stream with decode always ready
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("s_en",    rom_en_o,   1);
            chk("s_addr",  rom_addr_o, 32'(4*k));
            chk("s_valid", de_valid_o, (k >= 2));
            if (k >= 2) begin
                chk("s_pc",   de_pc_o,   32'(4*(k-2)));
                chk("s_inst", de_inst_o, 32'(4*(k-2)) ^ K);
            end
            nxt();
        end

        // Reset mid-stream: in-flight data must not land
        rst_n = 1'b0;
        smp();
        chk("mr_en",    rom_en_o,   0);
        chk("mr_addr",  rom_addr_o, 0);
        chk("mr_valid", de_valid_o, 0);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("mr_valid1", de_valid_o, 0);
        chk("mr_pc1",    de_pc_o,    0);
        chk("mr_en1",    rom_en_o,   1);
        chk("mr_addr1",  rom_addr_o, 0);
        nxt(); smp();
        chk("mr_valid2", de_valid_o, 0);
        nxt(); smp();
        chk("mr_valid3", de_valid_o, 1);
        chk("mr_pc3",    de_pc_o,    0);
        nxt();

        // Stall: exactly DEPTH issues, head held, then gapless drain
        do_reset(1'b0);
        nen = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (rom_en_o) nen++;
            nxt();
        end
        chk("st_issues", 64'(nen), 4);
        smp();
        chk("st_valid", de_valid_o, 1);
        chk("st_pc",    de_pc_o,    0);
        chk("st_inst",  de_inst_o,  K);
        chk("st_en",    rom_en_o,   0);
        nxt();
        de_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rl_valid", de_valid_o, 1);
            chk("rl_pc",    de_pc_o,    32'(4*k));
            nxt();
        end

        // Redirect with 3 queued and 1 in flight
        do_reset(1'b0);
        nxt(); nxt(); nxt(); nxt();
        jump_en_i = 1'b1; jump_addr_i = 32'h100;
        smp();
        chk("j_valid0", de_valid_o, 0);
        chk("j_en0",    rom_en_o,   1);
        chk("j_addr0",  rom_addr_o, 32'h100);
        nxt();
        jump_en_i = 1'b0; de_ready_i = 1'b1;
        smp();
        chk("j_valid1", de_valid_o, 0);
        nxt(); smp();
        chk("j_valid2", de_valid_o, 1);
        chk("j_pc2",    de_pc_o,    32'h100);
        chk("j_inst2",  de_inst_o,  32'h100 ^ K);
        nxt(); smp();
        chk("j_pc3", de_pc_o, 32'h104);
        nxt(); smp();
        chk("j_pc4", de_pc_o, 32'h108);
        nxt();

        // Back-to-back redirects: last target wins
        jump_en_i = 1'b1; jump_addr_i = 32'h200;
        smp();
        chk("jj_valid0", de_valid_o, 0);
        nxt();
        jump_addr_i = 32'h300;
        smp();
        chk("jj_addr1",  rom_addr_o, 32'h300);
        chk("jj_valid1", de_valid_o, 0);
        nxt();
        jump_en_i = 1'b0;
        smp();
        chk("jj_valid2", de_valid_o, 0);
        chk("jj_addr2",  rom_addr_o, 32'h304);
        nxt(); smp();
        chk("jj_valid3", de_valid_o, 1);
        chk("jj_pc3",    de_pc_o,    32'h300);
        nxt(); smp();
        chk("jj_pc4", de_pc_o, 32'h304);
        nxt();

        // PC wrap at top of address space
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
        smp();
        chk("w_addr0", rom_addr_o, 32'hFFFF_FFF8);
        nxt();
        jump_en_i = 1'b0;
        smp();
        chk("w_addr1", rom_addr_o, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("w_addr2", rom_addr_o, 32'h0);
        chk("w_pc2",   de_pc_o,    32'hFFFF_FFF8);
        nxt(); smp();
        chk("w_pc3", de_pc_o, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("w_pc4",    de_pc_o,    32'h0);
        chk("w_valid4", de_valid_o, 1);
        nxt();

`ifdef IFU_PERF_CNT_EN
        // 7 pops, then a redirect, then reset
        do_reset(1'b1);
        for (int k = 0; k < 9; k++) nxt();
        de_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h40;
        nxt();
        jump_en_i = 1'b0;
        smp();
        chk("pf_cnt", perf_fetch_cnt_o, 7);
        nxt();
        rst_n = 1'b0;
        nxt(); smp();
        chk("pf_rst",   perf_fetch_cnt_o, 0);
        chk("pf_valid", de_valid_o,       0);
        nxt();
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
